// File: rtl/microwave_panel_fsm.sv
// microwave_panel_fsm: keypad front panel that sets a cook time, requests the range, and beeps on completion
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   key_valid  one-cycle key strobe
//   key_code   0-9 digit, 10 START, 11 STOP/CLEAR, 12 ADD, 13-15 ignored
//   p          running status fed back from the range
//   tin        cook time to the range, held while r=1
//   r          run request
//   beep       completion tone, BEEP_CYCLES cycles
//   err        latched no-acknowledge fault
//   busy       high while arming or cooking
// Optional feature: define PANEL_ADD_KEY_EN to accept key 12 (ADD, +1 saturating) in IDLE and ENTRY.
module microwave_panel_fsm #(
    parameter int BEEP_CYCLES = 8,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       p,
    output logic [3:0] tin,
    output logic       r,
    output logic       beep,
    output logic       err,
    output logic       busy
);
    typedef enum logic [2:0] {IDLE, ENTRY, ARM, COOK, DONE, FAULT} state_t;
    state_t state, state_n;
    logic [3:0] tin_n, ack_cnt, ack_cnt_n;
    logic [7:0] beep_cnt, beep_cnt_n, mul;
    logic p_q, digit, start, stop;
    assign digit = key_valid && key_code <= 4'd9;
    assign start = key_valid && key_code == 4'd10;
    assign stop  = key_valid && key_code == 4'd11;
    // Worst case 15*10+9 = 159 still fits in 8 bits before saturating
    assign mul = {4'd0, tin} * 8'd10 + {4'd0, key_code};
`ifdef PANEL_ADD_KEY_EN
    logic add;
    logic [3:0] tin_inc;
    assign add = key_valid && key_code == 4'd12;
    assign tin_inc = (tin == 4'd15) ? 4'd15 : tin + 4'd1;
`endif
    always_comb begin
        state_n    = state;
        tin_n      = tin;
        ack_cnt_n  = ack_cnt;
        beep_cnt_n = beep_cnt;
        case (state)
            IDLE: begin
                tin_n = 4'd0;
                if (digit) begin
                    state_n = ENTRY;
                    tin_n   = key_code;
                end
`ifdef PANEL_ADD_KEY_EN
                else if (add) begin
                    state_n = ENTRY;
                    tin_n   = tin_inc;
                end
`endif
            end
            ENTRY: begin
                if (stop) begin
                    state_n = IDLE;
                    tin_n   = 4'd0;
                end else if (digit)
                    tin_n = (mul > 8'd15) ? 4'd15 : mul[3:0];
                else if (start && tin != 4'd0) begin
                    state_n   = ARM;
                    ack_cnt_n = 4'd0;
                end
`ifdef PANEL_ADD_KEY_EN
                else if (add)
                    tin_n = tin_inc;
`endif
            end
            ARM: begin
                // STOP beats acknowledge, acknowledge beats timeout
                if (stop) begin
                    state_n = IDLE;
                    tin_n   = 4'd0;
                end else if (p)
                    state_n = COOK;
                else if (ack_cnt == 4'(ACK_TIMEOUT - 1))
                    state_n = FAULT;
                else
                    ack_cnt_n = ack_cnt + 4'd1;
            end
            COOK: begin
                if (stop) begin
                    state_n = IDLE;
                    tin_n   = 4'd0;
                end else if (p_q && !p) begin
                    state_n    = DONE;
                    beep_cnt_n = 8'd0;
                end
            end
            DONE: begin
                if (stop || beep_cnt == 8'(BEEP_CYCLES - 1)) begin
                    state_n = IDLE;
                    tin_n   = 4'd0;
                end else
                    beep_cnt_n = beep_cnt + 8'd1;
            end
            FAULT: begin
                if (stop) begin
                    state_n = IDLE;
                    tin_n   = 4'd0;
                end
            end
            default: begin
                state_n = IDLE;
                tin_n   = 4'd0;
            end
        endcase
    end
    // Outputs are decoded from the next state so they are true flops aligned with the state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            tin      <= 4'd0;
            ack_cnt  <= 4'd0;
            beep_cnt <= 8'd0;
            p_q      <= 1'b0;
            r        <= 1'b0;
            beep     <= 1'b0;
            err      <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            tin      <= tin_n;
            ack_cnt  <= ack_cnt_n;
            beep_cnt <= beep_cnt_n;
            p_q      <= p;
            r        <= state_n == ARM || state_n == COOK;
            beep     <= state_n == DONE;
            err      <= state_n == FAULT;
            busy     <= state_n == ARM || state_n == COOK;
        end
    end
endmodule

// File: tb/tb_microwave_panel_fsm.sv
// tb_microwave_panel_fsm: scoreboard bench for the microwave front panel
module tb_microwave_panel_fsm;
    localparam logic [3:0] START = 4'd10, STOP = 4'd11, ADD = 4'd12;
    logic clk = 1'b0, rst = 1'b0, key_valid = 1'b0, p = 1'b0;
    logic [3:0] key_code = 4'd0, tin;
    logic r, beep, err, busy;
    logic [7:0] obs;
    int checks = 0, errors = 0;
    typedef struct {
        string tag;
        logic [7:0] exp;
    } sb_t;
    sb_t sbq[$];
    sb_t cur;

    microwave_panel_fsm dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code), .p(p),
        .tin(tin), .r(r), .beep(beep), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;
    assign obs = {tin, r, beep, err, busy};

    function automatic logic [7:0] e(input logic [3:0] t, input logic rr, input logic bb,
                                     input logic ee, input logic bs);
        return {t, rr, bb, ee, bs};
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got tin=%0d r=%b beep=%b err=%b busy=%b exp tin=%0d r=%b beep=%b err=%b busy=%b",
                     tag, got[7:4], got[3], got[2], got[1], got[0], exp[7:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    // Drive one cycle of stimulus and queue the outputs expected after the next edge
    task automatic cyc(input logic kv, input logic [3:0] code, input logic pv,
                       input logic [7:0] ex, input string tag);
        @(negedge clk);
        key_valid = kv;
        key_code  = code;
        p         = pv;
        sbq.push_back('{tag, ex});
    endtask

    task automatic k(input logic [3:0] code, input logic pv, input logic [7:0] ex, input string tag);
        cyc(1'b1, code, pv, ex, tag);
    endtask

    task automatic n(input logic pv, input logic [7:0] ex, input string tag);
        cyc(1'b0, 4'd0, pv, ex, tag);
    endtask

    task automatic flush;
        @(negedge clk);
        key_valid = 1'b0;
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        #1;
        if (sbq.size() != 0) begin
            cur = sbq.pop_front();
            chk(cur.tag, obs, cur.exp);
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk("reset_held", obs, e(0, 0, 0, 0, 0));
        rst = 1'b1;
        #1;
        chk("reset_out", obs, e(0, 0, 0, 0, 0));
        // normal cook
        k(4'd3, 0, e(3, 0, 0, 0, 0), "n_digit");
        k(START, 0, e(3, 1, 0, 0, 1), "n_start");
        n(0, e(3, 1, 0, 0, 1), "n_arm");
        n(1, e(3, 1, 0, 0, 1), "n_ack");
        for (int i = 0; i < 9; i++) n(1, e(3, 1, 0, 0, 1), "n_cook");
        n(0, e(3, 0, 1, 0, 0), "n_fall");
        for (int i = 0; i < 7; i++) n(0, e(3, 0, 1, 0, 0), "n_beep");
        n(0, e(0, 0, 0, 0, 0), "n_end");
        // digit entry and saturation
        k(4'd1, 0, e(1, 0, 0, 0, 0), "d_1");
        k(4'd2, 0, e(12, 0, 0, 0, 0), "d_12");
        k(4'd13, 0, e(12, 0, 0, 0, 0), "d_ign13");
        k(STOP, 0, e(0, 0, 0, 0, 0), "d_stop");
        k(4'd1, 0, e(1, 0, 0, 0, 0), "d_1b");
        k(4'd9, 0, e(15, 0, 0, 0, 0), "d_sat");
        k(4'd4, 0, e(15, 0, 0, 0, 0), "d_sticky");
        k(STOP, 0, e(0, 0, 0, 0, 0), "d_clr");
        // empty start
        k(START, 0, e(0, 0, 0, 0, 0), "es_idle");
        k(STOP, 0, e(0, 0, 0, 0, 0), "es_stop");
        k(4'd0, 0, e(0, 0, 0, 0, 0), "es_zero");
        k(START, 0, e(0, 0, 0, 0, 0), "es_entry");
        k(STOP, 0, e(0, 0, 0, 0, 0), "es_clr");
        // ack timeout and fault
        k(4'd5, 0, e(5, 0, 0, 0, 0), "t_digit");
        k(START, 0, e(5, 1, 0, 0, 1), "t_start");
        for (int i = 0; i < 3; i++) n(0, e(5, 1, 0, 0, 1), "t_arm");
        n(0, e(5, 0, 0, 1, 0), "t_fault");
        k(4'd7, 0, e(5, 0, 0, 1, 0), "t_digit_ign");
        k(START, 0, e(5, 0, 0, 1, 0), "t_start_ign");
        k(STOP, 0, e(0, 0, 0, 0, 0), "t_clear");
        // ack wins over timeout, STOP beats fall
        k(4'd5, 0, e(5, 0, 0, 0, 0), "a_digit");
        k(START, 0, e(5, 1, 0, 0, 1), "a_start");
        for (int i = 0; i < 3; i++) n(0, e(5, 1, 0, 0, 1), "a_arm");
        n(1, e(5, 1, 0, 0, 1), "a_ack_at_to");
        k(4'd9, 1, e(5, 1, 0, 0, 1), "a_cook_key");
        k(STOP, 0, e(0, 0, 0, 0, 0), "a_stop_fall");
        n(0, e(0, 0, 0, 0, 0), "a_nobeep");
        // STOP beats timeout
        k(4'd6, 0, e(6, 0, 0, 0, 0), "s_digit");
        k(START, 0, e(6, 1, 0, 0, 1), "s_start");
        for (int i = 0; i < 3; i++) n(0, e(6, 1, 0, 0, 1), "s_arm");
        k(STOP, 0, e(0, 0, 0, 0, 0), "s_stop_to");
        n(0, e(0, 0, 0, 0, 0), "s_nofault");
        // STOP ends beep early
        k(4'd2, 0, e(2, 0, 0, 0, 0), "b_digit");
        k(START, 1, e(2, 1, 0, 0, 1), "b_start");
        n(1, e(2, 1, 0, 0, 1), "b_ack");
        n(0, e(2, 0, 1, 0, 0), "b_fall");
        k(STOP, 0, e(0, 0, 0, 0, 0), "b_stop");
        // add key
        k(4'd1, 0, e(1, 0, 0, 0, 0), "ad_1");
        k(4'd4, 0, e(14, 0, 0, 0, 0), "ad_14");
`ifdef PANEL_ADD_KEY_EN
        k(ADD, 0, e(15, 0, 0, 0, 0), "ad_add1");
        k(ADD, 0, e(15, 0, 0, 0, 0), "ad_add2");
        k(STOP, 0, e(0, 0, 0, 0, 0), "ad_stop");
        k(ADD, 0, e(1, 0, 0, 0, 0), "ad_idle");
`else
        k(ADD, 0, e(14, 0, 0, 0, 0), "ad_add1");
        k(ADD, 0, e(14, 0, 0, 0, 0), "ad_add2");
        k(STOP, 0, e(0, 0, 0, 0, 0), "ad_stop");
        k(ADD, 0, e(0, 0, 0, 0, 0), "ad_idle");
`endif
        k(STOP, 0, e(0, 0, 0, 0, 0), "ad_clr");
        // asynchronous reset mid-cook
        k(4'd4, 0, e(4, 0, 0, 0, 0), "r_digit");
        k(START, 1, e(4, 1, 0, 0, 1), "r_start");
        n(1, e(4, 1, 0, 0, 1), "r_ack");
        n(1, e(4, 1, 0, 0, 1), "r_cook");
        flush();
        rst = 1'b0;
        #1;
        chk("r_async", obs, e(0, 0, 0, 0, 0));
        p = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        n(0, e(0, 0, 0, 0, 0), "r_after");
        flush();
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL sb_drain left=%0d required=0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/microwave_panel_fsm.md
# microwave_panel_fsm

Front-panel controller that drives the microwave range core from the user side. It collects keypad strokes into a 4-bit cook time, raises the run request toward the range, and watches the range's power output to confirm start-up and detect completion. On completion it beeps for a fixed time. If the range never acknowledges the run request, it latches a fault.

## Interface
Parameters:
- BEEP_CYCLES, 8, clock cycles `beep` stays high after completion (1..255)
- ACK_TIMEOUT, 4, cycles allowed in ARM for `p` to rise before fault (1..15)

Ports:
- clk  input  1  single clock; all state changes on its rising edge
- rst  input  1  asynchronous, active-low reset
- key_valid  input  1  one-cycle strobe; `key_code` is sampled when high
- key_code  input  4  0–9 digit; 10 START; 11 STOP/CLEAR; 12 ADD (see Configuration); 13–15 ignored
- p  input  1  power/running status fed back from the range
- tin  output  4  cook time presented to the range; held stable while `r`=1
- r  output  1  run request level to the range
- beep  output  1  completion tone
- err  output  1  no-acknowledge fault, latched
- busy  output  1  high in ARM or COOK

## Operation
States: IDLE, ENTRY, ARM, COOK, DONE, FAULT. All outputs are registered.
- IDLE: `tin`=0, `r`=0.
  - Digit d → ENTRY, `tin`=d.
  - START, STOP and ADD (macro off) are ignored.
- ENTRY:
  - Digit d → `tin` = min(`tin`*10 + d, 15). Compute in 8 bits, then saturate.
  - STOP → IDLE, `tin`=0.
  - START with `tin`≠0 → ARM, `r`=1, ack counter cleared.
  - START with `tin`=0 is ignored.
- ARM: `r`=1.
  - `p`=1 → COOK.
  - STOP → IDLE (`r`=0, `tin`=0).
  - Ack counter reaches ACK_TIMEOUT with `p` still 0 → FAULT.
- COOK: `r`=1.
  - Falling `p` (sampled 1 last cycle, 0 now) → DONE.
  - STOP → IDLE with no beep.
  - All other keys are ignored.
- DONE: `r`=0, `beep`=1.
  - Beep counter runs BEEP_CYCLES cycles, then → IDLE with `tin`=0.
  - STOP ends the beep early → IDLE.
- FAULT: `err`=1, `r`=0.
  - Only STOP exits → IDLE, which clears `err` and `tin`.
- Keys with codes 13–15 are ignored in every state.
- `key_valid`=0 means no key event.

## Timing
- Reset: state IDLE. `tin`=0, `r`=0, `beep`=0, `err`=0, `busy`=0, counters 0.
- Reset asserted mid-COOK drops `r` immediately (asynchronously).
- START accepted in cycle n → `r`=1 and `busy`=1 from cycle n+1.
- Ack latency:
  - `p` first seen high in cycle k of ARM → COOK from k+1.
  - `p` still low after ACK_TIMEOUT ARM cycles → `err`=1, `r`=0 on the next edge.
- Completion: `p` falling edge seen in cycle m → `r`=0 and `beep`=1 from m+1, for exactly BEEP_CYCLES cycles.
- STOP priority:
  - STOP in the same cycle as a `p` fall in COOK → IDLE, no beep.
  - STOP in the same cycle as ack timeout in ARM → IDLE, no fault.
- `p` rising in the same cycle as ack timeout → COOK; the acknowledge wins.
- `tin` never changes while `r`=1.
- Digit saturation is sticky: once `tin`=15, further digits keep it at 15.

## Configuration
- PANEL_ADD_KEY_EN defined: key 12 (ADD) is accepted in IDLE and ENTRY.
  - Sets `tin` = min(`tin`+1, 15).
  - From IDLE it moves the FSM to ENTRY.
  - It is ignored in every other state.
- PANEL_ADD_KEY_EN undefined: key 12 is ignored everywhere, and no increment logic is built.

## Test plan
- Normal cook (defaults):
  - Stimulus: keys 3, then START; `p` rises 2 cycles after `r`, then falls 10 cycles later.
  - Required: `tin`=3, `r`=1 the cycle after START, `busy`=1 through COOK; `r`=0 and `beep`=1 the cycle after `p` falls; `beep` high exactly 8 cycles, then `tin`=0.
- Digit entry:
  - Keys 1,2 → `tin`=12.
  - STOP, then keys 1,9 → `tin`=15 (saturated); an extra digit 4 → `tin` stays 15.
- Empty START:
  - From reset, START, then STOP → `r` stays 0, state stays IDLE, `err`=0.
- Ack timeout:
  - Keys 5, START, `p` held 0 → `err`=1 and `r`=0 after 4 ARM cycles.
  - STOP → `err`=0, `tin`=0.
- Simultaneous events:
  - In COOK, STOP in the same cycle `p` falls → IDLE; `beep` never asserts.
  - Assert `rst` low mid-COOK → `r`=0 immediately.
- PANEL_ADD_KEY_EN:
  - Macro defined: keys 1,4, then ADD ×2 → `tin` 15, 15.
  - Macro undefined: same sequence → `tin` stays 14.
